vedic_mul_seq_8x8: RTL and testbench

VEDIC_MUL_SEQ_8X8 -- requirements
Module: vedic_mul_seq_8x8

---
 rtl/vedic_pkg.sv | 24 ++
 rtl/vedic_mul_4_4.sv | 19 +
 rtl/vedic_mul_seq_8x8.sv | 127 ++++++++++++
 tb/tb_vedic_mul_seq_8x8.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential Vedic 8x8 multiplier: FSM encoding,
// step count and the 2x2 Urdhva-Tiryagbhyam building block.
package vedic_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned NSTEPS = 4;

  // Vertical-and-crosswise 2x2 product: outer bits vertically, middle column crosswise.
  function automatic logic [3:0] vedic_mul_2x2(input logic [1:0] x, input logic [1:0] y);
    logic p0, p1, p2, p3, c1;
    p0 = x[0] & y[0];
    p1 = (x[1] & y[0]) ^ (x[0] & y[1]);
    c1 = (x[1] & y[0]) & (x[0] & y[1]);
    p2 = (x[1] & y[1]) ^ c1;
    p3 = (x[1] & y[1]) & c1;
    return {p3, p2, p1, p0};
  endfunction

endpackage

// File: rtl/vedic_mul_4_4.sv
// Combinational 4x4 Vedic multiplier assembled from four 2x2 Vedic blocks.
module vedic_mul_4_4
  import vedic_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);

  logic [3:0] q_ll, q_lh, q_hl, q_hh;

  assign q_ll = vedic_mul_2x2(x[1:0], y[1:0]);
  assign q_lh = vedic_mul_2x2(x[1:0], y[3:2]);
  assign q_hl = vedic_mul_2x2(x[3:2], y[1:0]);
  assign q_hh = vedic_mul_2x2(x[3:2], y[3:2]);

  assign p = {4'b0, q_ll} + {2'b0, q_lh, 2'b0} + {2'b0, q_hl, 2'b0} + {q_hh, 4'b0};

endmodule

// File: rtl/vedic_mul_seq_8x8.sv
// Sequential 8x8 unsigned multiplier: one shared 4x4 Vedic core stepped over the
// four nibble pairs, accumulated into a 16-bit register, valid/ready on both sides.
module vedic_mul_seq_8x8
  import vedic_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);

  localparam logic [1:0] LastStep = 2'(NSTEPS - 1);

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [15:0] product_q, product_d;

  logic [3:0]  a_nib, b_nib;
  logic [7:0]  pp;
  logic [15:0] pp_shifted;
  logic        accept;

  // step[1] selects the a nibble, step[0] the b nibble.
  assign a_nib = step_q[1] ? a_q[7:4] : a_q[3:0];
  assign b_nib = step_q[0] ? b_q[7:4] : b_q[3:0];

  vedic_mul_4_4 u_mul (
    .x (a_nib),
    .y (b_nib),
    .p (pp)
  );

  always_comb begin
    pp_shifted = 16'h0000;
    unique case (step_q)
      2'd0:    pp_shifted = {8'h00, pp};
      2'd1:    pp_shifted = {4'h0, pp, 4'h0};
      2'd2:    pp_shifted = {4'h0, pp, 4'h0};
      default: pp_shifted = {pp, 8'h00};
    endcase
  end

  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign product   = product_q;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    product_d = product_q;
    if (clr) begin
      state_d = StIdle;
      step_d  = 2'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_d = StCalc;
            step_d  = 2'd0;
            acc_d   = 16'h0000;
            a_d     = a;
            b_d     = b;
          end
        end
        StCalc: begin
          acc_d  = acc_q + pp_shifted;
          step_d = step_q + 2'd1;
          if (step_q == LastStep) begin
            state_d   = StDone;
            product_d = acc_d;
          end
        end
        StDone: begin
          if (out_ready) begin
            // in_ready is high here, so a pending operand is taken in the same cycle.
            if (in_valid) begin
              state_d = StCalc;
              step_d  = 2'd0;
              acc_d   = 16'h0000;
              a_d     = a;
              b_d     = b;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: begin
          state_d = StIdle;
          step_d  = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      step_q    <= 2'd0;
      acc_q     <= 16'h0000;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      product_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_vedic_mul_seq_8x8.sv
// Directed self-checking bench for vedic_mul_seq_8x8.
module tb_vedic_mul_seq_8x8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vedic_mul_seq_8x8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until out_valid is seen or the budget runs out; n counts edges taken.
  task automatic wait_valid(output int n);
    n = 1;
    tick();
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; a = 8'h00; b = 8'h00; out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({in_ready, out_valid, busy, product} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset: in_ready/out_valid/busy/product = %b/%b/%b/%h, want 1/0/0/0000",
               in_ready, out_valid, busy, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    out_ready = 1'b1;
    a = 8'h12; b = 8'h34; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL first_accept: busy = %b, want 1", busy);
    end
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 5 || product !== 16'h03A8) begin
      errors++;
      $display("FAIL basic: latency %0d product %h, want 5 03a8", n, product);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: out_valid %b busy %b, want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_corners();
    logic [7:0]  va [2] = '{8'hFF, 8'h00};
    logic [7:0]  vb [2] = '{8'hFF, 8'hAB};
    logic [15:0] vp [2] = '{16'hFE01, 16'h0000};
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = va[i]; b = vb[i]; in_valid = 1'b1;
      tick();
      // Junk on the inputs during CALC must not be taken.
      a = 8'h5A; b = 8'hC3;
      tick();
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL corner_calc_ready[%0d]: in_ready %b, want 0", i, in_ready);
      end
      tick();
      in_valid = 1'b0;
      n = 3;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (n !== 5 || product !== vp[i]) begin
        errors++;
        $display("FAIL corner[%0d]: latency %0d product %h, want 5 %h", i, n, product, vp[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    out_ready = 1'b0;
    a = 8'h0F; b = 8'h10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL bp_latency: %0d, want 5", n);
    end
    bad = 0;
    a = 8'hEE; b = 8'hEE; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (out_valid !== 1'b1 || product !== 16'h00F0 || in_ready !== 1'b0) bad++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: %0d bad cycles, want 0 (product %h)", bad, product);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || product !== 16'h00F0) begin
      errors++;
      $display("FAIL bp_release: in_ready %b product %h, want 1 00f0", in_ready, product);
    end
    tick();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_single_handshake: %0d cycles still active, want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b1;
    a = 8'h0F; b = 8'h10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 5 || product !== 16'h00F0) begin
      errors++;
      $display("FAIL b2b_first: latency %0d product %h, want 5 00f0", n, product);
    end
    a = 8'h80; b = 8'h02; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: in_ready %b, want 1", in_ready);
    end
    wait_valid(n);
    in_valid = 1'b0;
    checks++;
    if (n !== 5 || product !== 16'h0100) begin
      errors++;
      $display("FAIL b2b_second: spacing %0d product %h, want 5 0100", n, product);
    end
    tick();
  endtask

  task automatic test_abort();
    int n;
    int bad;
    out_ready = 1'b1;
    a = 8'h55; b = 8'hAA; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: busy %b out_valid %b in_ready %b, want 0 0 1",
               busy, out_valid, in_ready);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL abort_no_valid: %0d cycles with out_valid, want 0", bad);
    end
    a = 8'h03; b = 8'h05; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 5 || product !== 16'h000F) begin
      errors++;
      $display("FAIL abort_next: latency %0d product %h, want 5 000f", n, product);
    end
    // clr beats a simultaneous handshake plus new accept.
    a = 8'h11; b = 8'h22; in_valid = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_priority: busy %b out_valid %b, want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_async_reset();
    int bad;
    out_ready = 1'b1;
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, product} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL async_reset: in_ready/out_valid/busy/product = %b/%b/%b/%h, want 1/0/0/0000",
               in_ready, out_valid, busy, product);
    end
    #1;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL async_no_stale: %0d active cycles after release, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
